// File: rtl/chdr_file_sink.sv
// CHDR capture sink: parses headers/timestamps, undoes sample-swap and endianness, stores payload words.
// Define CHDR_FILE_SINK_READBACK_EN to add a registered readback port (rb_addr/rb_data) on the word memory.
module chdr_file_sink #(
  parameter logic [7:0] SR_ENABLE            = 8'd0,
  parameter logic [7:0] SR_CLEAR             = 8'd1,
  parameter logic [7:0] SR_SWAP_SAMPLES      = 8'd4,
  parameter logic [7:0] SR_ENDIANNESS        = 8'd5,
  parameter logic [1:0] DEFAULT_SWAP_SAMPLES = 2'd2,
  parameter logic [1:0] DEFAULT_ENDIANNESS   = 2'd2,
  parameter int         FILE_LENGTH          = 65536
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              set_stb,
  input  logic [7:0]                        set_addr,
  input  logic [31:0]                       set_data,
  input  logic [63:0]                       i_tdata,
  input  logic                              i_tlast,
  input  logic                              i_tvalid,
  output logic                              i_tready,
  output logic [15:0]                       pkt_count,
  output logic [$clog2(FILE_LENGTH/8):0]    word_count,
  output logic [31:0]                       last_sid,
  output logic [63:0]                       last_time,
  output logic                              seq_err,
  output logic                              len_err,
  output logic                              overflow
`ifdef CHDR_FILE_SINK_READBACK_EN
  ,
  input  logic [$clog2(FILE_LENGTH/8)-1:0]  rb_addr,
  output logic [63:0]                       rb_data
`endif
);

  localparam int DEPTH = FILE_LENGTH / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_HEAD, ST_TIME, ST_DATA, ST_DROP} state_t;

  state_t      r_state, w_state_next;
  logic        r_enable;
  logic [1:0]  r_swap, r_endian;
  logic [15:0] r_pkt_count;
  logic [AW:0] r_word_count;
  logic [31:0] r_last_sid;
  logic [63:0] r_last_time;
  logic        r_seq_err, r_len_err, r_overflow;
  logic        r_seq_valid;
  logic [11:0] r_seq_exp;
  logic [16:0] r_exp_beats, r_beats;
  logic [63:0] r_mem [DEPTH];

  logic        w_fire, w_clear, w_hdr, w_done, w_store, w_time_cap, w_len_bad;
  logic        w_full, w_mem_we, w_ovf_hit;
  logic [AW:0] w_wptr;
  logic [16:0] w_beat_cnt;
  logic [63:0] w_swap8, w_swapped, w_final;
  logic        w_unused_set_data;

  // Header fields
  logic        w_h_time, w_h_short;
  logic [11:0] w_h_seq;
  logic [15:0] w_h_len, w_h_hdr_bytes, w_h_payload;
  logic [16:0] w_h_exp;

  assign w_h_time      = i_tdata[61];
  assign w_h_seq       = i_tdata[59:48];
  assign w_h_len       = i_tdata[47:32];
  assign w_h_hdr_bytes = w_h_time ? 16'd16 : 16'd8;
  assign w_h_short     = w_h_len < w_h_hdr_bytes;
  assign w_h_payload   = w_h_len - w_h_hdr_bytes;
  assign w_h_exp       = w_h_short ? 17'd0 : (({1'b0, w_h_payload} + 17'd7) >> 3);

  assign i_tready   = ~reset;
  assign w_fire     = i_tvalid & i_tready;
  assign w_clear    = set_stb & (set_addr == SR_CLEAR);
  assign w_beat_cnt = r_beats + 17'd1;
  assign w_unused_set_data = ^set_data[31:2];

  // A clear retargets the current beat to address 0
  assign w_wptr    = w_clear ? '0 : r_word_count;
  assign w_full    = (w_wptr == FULL_COUNT);
  assign w_mem_we  = w_store & ~w_full;
  assign w_ovf_hit = w_store & w_full;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_swap8
      assign w_swap8[gi*16 +: 16] = {i_tdata[gi*16 +: 8], i_tdata[gi*16+8 +: 8]};
    end
  endgenerate

  always_comb begin
    w_swapped = i_tdata;
    case (r_swap)
      2'd1:    w_swapped = w_swap8;
      2'd2:    w_swapped = {i_tdata[47:32], i_tdata[63:48], i_tdata[15:0], i_tdata[31:16]};
      2'd3:    w_swapped = {i_tdata[31:0], i_tdata[63:32]};
      default: w_swapped = i_tdata;
    endcase
  end

  generate
    for (gi = 0; gi < 2; gi++) begin : g_endian
      logic [31:0] w_lane;
      assign w_lane = w_swapped[gi*32 +: 32];
      assign w_final[gi*32 +: 32] =
        (r_endian == 2'd1) ? {w_lane[15:0], w_lane[31:16]} :
        (r_endian == 2'd2) ? {w_lane[7:0], w_lane[15:8], w_lane[23:16], w_lane[31:24]} :
        (r_endian == 2'd3) ? 32'd0 : w_lane;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_HEAD;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_hdr        = 1'b0;
    w_done       = 1'b0;
    w_store      = 1'b0;
    w_time_cap   = 1'b0;
    w_len_bad    = 1'b0;
    if (w_fire) begin
      case (r_state)
        ST_HEAD: begin
          w_hdr = 1'b1;
          if (i_tlast) begin
            w_done    = 1'b1;
            w_len_bad = w_h_short | (w_h_exp != 17'd0);
          end else begin
            w_len_bad    = w_h_short;
            w_state_next = !r_enable ? ST_DROP : (w_h_time ? ST_TIME : ST_DATA);
          end
        end
        ST_TIME: begin
          w_time_cap = 1'b1;
          if (i_tlast) begin
            w_done       = 1'b1;
            w_len_bad    = (r_exp_beats != 17'd0);
            w_state_next = ST_HEAD;
          end else begin
            w_state_next = ST_DATA;
          end
        end
        ST_DATA: begin
          w_store = 1'b1;
          if (i_tlast) begin
            w_done       = 1'b1;
            w_len_bad    = (w_beat_cnt != r_exp_beats);
            w_state_next = ST_HEAD;
          end else begin
            // Reaching the expected count without tlast is already an error
            w_len_bad = (w_beat_cnt >= r_exp_beats);
          end
        end
        ST_DROP: begin
          if (i_tlast) begin
            w_done       = 1'b1;
            w_state_next = ST_HEAD;
          end
        end
        default: w_state_next = ST_HEAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable     <= 1'b0;
      r_swap       <= DEFAULT_SWAP_SAMPLES;
      r_endian     <= DEFAULT_ENDIANNESS;
      r_pkt_count  <= '0;
      r_word_count <= '0;
      r_last_sid   <= '0;
      r_last_time  <= '0;
      r_seq_err    <= 1'b0;
      r_len_err    <= 1'b0;
      r_overflow   <= 1'b0;
      r_seq_valid  <= 1'b0;
      r_seq_exp    <= '0;
      r_exp_beats  <= '0;
      r_beats      <= '0;
    end else begin
      if (set_stb && set_addr == SR_ENABLE)       r_enable <= set_data[0];
      if (set_stb && set_addr == SR_SWAP_SAMPLES) r_swap   <= set_data[1:0];
      if (set_stb && set_addr == SR_ENDIANNESS)   r_endian <= set_data[1:0];
      if (w_hdr) begin
        r_last_sid  <= i_tdata[31:0];
        r_exp_beats <= w_h_exp;
        r_beats     <= '0;
      end else if (w_store) begin
        r_beats <= w_beat_cnt;
      end
      if (w_time_cap) r_last_time <= i_tdata;
      r_word_count <= w_wptr + {{AW{1'b0}}, w_mem_we};
      r_pkt_count  <= w_clear ? 16'd0 : r_pkt_count + {15'd0, w_done};
      r_len_err    <= ~w_clear & (r_len_err | w_len_bad);
      r_overflow   <= ~w_clear & (r_overflow | w_ovf_hit);
      r_seq_err    <= ~w_clear & (r_seq_err | (w_hdr & r_seq_valid & (w_h_seq != r_seq_exp)));
      if (w_clear) r_seq_valid <= 1'b0;
      if (w_hdr) begin
        r_seq_valid <= 1'b1;
        r_seq_exp   <= w_h_seq + 12'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_wptr[AW-1:0]] <= w_final;
  end

`ifdef CHDR_FILE_SINK_READBACK_EN
  logic [63:0] r_rb_data;
  always_ff @(posedge clk) begin
    if (reset) r_rb_data <= '0;
    else       r_rb_data <= r_mem[rb_addr];
  end
  assign rb_data = r_rb_data;
`endif

  assign pkt_count  = r_pkt_count;
  assign word_count = r_word_count;
  assign last_sid   = r_last_sid;
  assign last_time  = r_last_time;
  assign seq_err    = r_seq_err;
  assign len_err    = r_len_err;
  assign overflow   = r_overflow;

endmodule
